// File: rtl/move_direction_input.sv
// Direction button front end: 2-flop sync, per-bit debounce, newest-press arbiter, tick-gated output.
// Optional STICKY_DIRECTION_EN: keep the last direction when no button is held.
module move_direction_input #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned CNT_W           = 24
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] btn_raw,
    input  logic       game_tick,
    output logic [3:0] move_direction,
    output logic [3:0] btn_stable,
    output logic [3:0] press_pulse
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]       sync1_q, sync2_q;
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];
    logic [3:0]       stable_q, stable_d;
    logic [3:0]       stable_dly_q;
    logic [3:0]       pulse_q;
    logic [3:0]       dir_next_q, dir_next_d;
    logic [3:0]       move_q;

    // Fixed priority RIGHT > LEFT > UP > DOWN
    function automatic logic [3:0] pick(input logic [3:0] v);
        logic [3:0] r;
        r = '0;
        if (v[0])      r = 4'b0001;
        else if (v[3]) r = 4'b1000;
        else if (v[1]) r = 4'b0010;
        else if (v[2]) r = 4'b0100;
        return r;
    endfunction

    always_comb begin
        stable_d = stable_q;
        for (int unsigned i = 0; i < 4; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_MAX) stable_d[i] = ~stable_q[i];
                else                     cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_comb begin
        dir_next_d = dir_next_q;
        if (|pulse_q) begin
            dir_next_d = pick(pulse_q);
        end else if (|(dir_next_q & stable_q)) begin
            dir_next_d = dir_next_q;
        end else if (|stable_q) begin
            dir_next_d = pick(stable_q);
        end else begin
`ifdef STICKY_DIRECTION_EN
            dir_next_d = dir_next_q;
`else
            dir_next_d = '0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            for (int unsigned i = 0; i < 4; i++) cnt_q[i] <= '0;
            stable_q     <= '0;
            stable_dly_q <= '0;
            pulse_q      <= '0;
            dir_next_q   <= '0;
            move_q       <= '0;
        end else begin
            sync1_q      <= btn_raw;
            sync2_q      <= sync1_q;
            for (int unsigned i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            pulse_q      <= stable_q & ~stable_dly_q;
            dir_next_q   <= dir_next_d;
            if (game_tick) move_q <= dir_next_q;
        end
    end

    assign move_direction = move_q;
    assign btn_stable     = stable_q;
    assign press_pulse    = pulse_q;

endmodule

// File: tb/tb_move_direction_input.sv
// Scoreboard bench for move_direction_input with DEBOUNCE_CYCLES=4.
module tb_move_direction_input;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] btn_raw;
    logic       game_tick;
    logic [3:0] move_direction, btn_stable, press_pulse;

    int checks   = 0;
    int failures = 0;

    logic [3:0] exp_dir_q   [$];
    logic [3:0] exp_pulse_q [$];

`ifdef STICKY_DIRECTION_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    always #5 clk = ~clk;

    move_direction_input #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (24)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn_raw       (btn_raw),
        .game_tick     (game_tick),
        .move_direction(move_direction),
        .btn_stable    (btn_stable),
        .press_pulse   (press_pulse)
    );

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, req, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; the tick is sampled at the next posedge
    task automatic tick(input logic [3:0] exp);
        game_tick = 1'b1;
        exp_dir_q.push_back(exp);
        @(negedge clk);
        game_tick = 1'b0;
    endtask

    // Monitor: move_direction is compared after every edge that sampled game_tick
    initial begin
        logic t;
        forever begin
            @(posedge clk);
            t = game_tick;
            @(negedge clk);
            if (t === 1'b1) begin
                if (exp_dir_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL dir_unexpected: got %b, expected no update at %0t", move_direction, $time);
                end else begin
                    check("move_direction", move_direction, exp_dir_q.pop_front());
                end
            end
        end
    end

    // Monitor: every non-zero press_pulse cycle must match a queued expectation
    initial begin
        forever begin
            @(negedge clk);
            if (press_pulse !== 4'b0000) begin
                if (exp_pulse_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL pulse_unexpected: got %b, expected 0000 at %0t", press_pulse, $time);
                end else begin
                    check("press_pulse", press_pulse, exp_pulse_q.pop_front());
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        btn_raw   = 4'b0000;
        game_tick = 1'b0;
        cyc(3);
        check("reset_move", move_direction, 4'b0000);
        check("reset_stable", btn_stable, 4'b0000);
        check("reset_pulse", press_pulse, 4'b0000);
        rst_n = 1'b1;

        // Idle with periodic ticks
        cyc(15); tick(4'b0000);
        cyc(15); tick(4'b0000);
        check("idle_stable", btn_stable, 4'b0000);

        // RIGHT press: stable rises 6 clk after the raw edge
        btn_raw = 4'b0001;
        exp_pulse_q.push_back(4'b0001);
        cyc(5);
        check("right_stable_early", btn_stable, 4'b0000);
        cyc(1);
        check("right_stable", btn_stable, 4'b0001);
        cyc(2);
        tick(4'b0001);

        // LEFT bounce never debounces
        for (int i = 0; i < 20; i++) begin
            btn_raw[3] = ~btn_raw[3];
            cyc(2);
        end
        cyc(3);
        check("bounce_stable", btn_stable, 4'b0001);
        tick(4'b0001);

        // LEFT pressed while RIGHT held: newest press wins
        btn_raw = 4'b1001;
        exp_pulse_q.push_back(4'b1000);
        tick(4'b0001);
        cyc(7);
        check("left_stable", btn_stable, 4'b1001);
        tick(4'b1000);

        // Release LEFT, RIGHT still held
        btn_raw = 4'b0001;
        cyc(7);
        check("left_release_stable", btn_stable, 4'b0001);
        tick(4'b0001);

        // Release everything
        btn_raw = 4'b0000;
        cyc(7);
        check("all_release_stable", btn_stable, 4'b0000);
        tick(STICKY ? 4'b0001 : 4'b0000);

        // UP and DOWN together: UP has priority
        btn_raw = 4'b0110;
        exp_pulse_q.push_back(4'b0110);
        cyc(8);
        check("updown_stable", btn_stable, 4'b0110);
        tick(4'b0010);

        btn_raw = 4'b0000;
        cyc(7);
        tick(STICKY ? 4'b0010 : 4'b0000);

        // Reset mid-count with DOWN held
        btn_raw = 4'b0100;
        cyc(4);
        rst_n = 1'b0;
        #1;
        check("midreset_move", move_direction, 4'b0000);
        check("midreset_stable", btn_stable, 4'b0000);
        check("midreset_pulse", press_pulse, 4'b0000);
        cyc(2);
        rst_n = 1'b1;
        exp_pulse_q.push_back(4'b0100);
        cyc(5);
        check("post_reset_stable_early", btn_stable, 4'b0000);
        cyc(1);
        check("post_reset_stable", btn_stable, 4'b0100);
        cyc(2);
        tick(4'b0100);

        cyc(10);
        checks++;
        if (exp_dir_q.size() != 0) begin
            failures++;
            $display("FAIL dir_queue: got %0d pending, expected 0", exp_dir_q.size());
        end
        checks++;
        if (exp_pulse_q.size() != 0) begin
            failures++;
            $display("FAIL pulse_queue: got %0d pending, expected 0", exp_pulse_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/move_direction_input.md
Name: move_direction_input

Overview:
- Upstream stage of position_update_function: turns four raw, asynchronous direction buttons into the one-hot 4-bit move_direction it consumes.
- Synchronises and debounces each button, then arbitrates between them (newest press wins).
- Changes its output only on a game_tick strobe, so move_direction is stable across every slower_clk edge.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive clk cycles a synchronised input must differ from its stable state before that state flips; legal range 1..2^24-1.
- CNT_W, 24, debounce counter width; must hold DEBOUNCE_CYCLES.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- btn_raw  in  4  raw buttons, bit map matches direction encoding: [0]=RIGHT, [1]=UP, [2]=DOWN, [3]=LEFT; active-high.
- game_tick  in  1  single-clk pulse in clk domain, one per slower_clk period, asserted the cycle before the slower_clk rising edge.
- move_direction  out  4  one-hot (RIGHT 0001, UP 0010, DOWN 0100, LEFT 1000) or 0000 = no move; registered.
- btn_stable  out  4  debounced button levels.
- press_pulse  out  4  one-clk pulse per bit on a debounced rising edge.

Behaviour:
- Reset (rst_n low, async): sync flops, counters, btn_stable, press_pulse, dir_next, move_direction all cleared to 0; release is synchronous to clk.
- Synchroniser: 2 flops per bit. Raw edge to synced output takes 2 clk.
- Debounce, per bit:
  - synced == stable: counter cleared.
  - synced != stable: counter increments.
  - When counter reaches DEBOUNCE_CYCLES-1 while still different: stable flips and counter clears in the same cycle.
  - Any bounce back to equality before that clears the counter.
  - Raw edge to btn_stable change = 2 + DEBOUNCE_CYCLES clk.
- press_pulse[i] = stable[i] & ~stable_d[i], registered; 1 clk after the btn_stable rise.
- Arbiter register dir_next, updated every clk:
  - Any press_pulse bit set: dir_next takes the pressed bit. If several pulse together, priority RIGHT > LEFT > UP > DOWN. A reversal (e.g. RIGHT->LEFT) is allowed.
  - No pulse, and current dir_next bit still held in btn_stable: unchanged.
  - No pulse, current bit released, other buttons still held: highest-priority held bit (same order).
  - No pulse, no button held: see Optional Feature.
- Output stage:
  - move_direction <= dir_next on the clk after a cycle with game_tick=1, i.e. game_tick in cycle N gives a new value in N+1; otherwise it holds.
  - Presses and releases between ticks are resolved only through dir_next; a press-and-release fully inside one tick window still registers if the sticky feature is on.
- Invariant: move_direction is always one-hot or zero; never two bits set.
- game_tick held high for multiple cycles: output tracks dir_next every cycle while high. Not a legal use, but defined.
- Reset asserted mid-debounce: all state cleared; a button still held after release needs a full DEBOUNCE_CYCLES again.
- Counter is saturation-free: it can never exceed DEBOUNCE_CYCLES-1 by construction.

Optional Feature:
- Macro STICKY_DIRECTION_EN.
- Defined: when no button is held, dir_next keeps its last value, so Pac-Man keeps moving in the last chosen direction (arcade behaviour). dir_next only returns to 0000 on reset.
- Undefined: when no button is held, dir_next becomes 0000, so position update stops the sprite on the next tick.

Test Plan (DEBOUNCE_CYCLES=4 in simulation):
- Reset then idle, ticks every 16 clk -> move_direction=0000, btn_stable=0000, no press_pulse.
- btn_raw=0001 held -> btn_stable[0] rises 6 clk after the edge, press_pulse=0001 for 1 clk, move_direction=0001 on the clk after the next game_tick.
- btn_raw[3] toggled 0/1 every 2 clk for 40 clk (bounce) -> btn_stable stays 0, move_direction unchanged.
- RIGHT held, then LEFT pressed -> move_direction 0001->1000 at the next tick; release LEFT with RIGHT still held -> 0001 at the following tick.
- UP and DOWN rise in the same clk -> press_pulse=0110, move_direction=0010; release both -> 0010 with STICKY_DIRECTION_EN, 0000 without.
- Assert rst_n low mid-count while btn_raw=0100 held, release reset -> all outputs 0 at once; btn_stable[2] rises 6 clk after the reset release.
